// File: rtl/cpu_ctrl_pkg.sv
// Shared control constants for the instruction sequencer: FSM encodings,
// opcodes, the latched-instruction record and the bus select encoding.
package cpu_ctrl_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD_A = 3'd1;
    localparam logic [2:0] ST_RD_B = 3'd2;
    localparam logic [2:0] ST_EXEC = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_AND = 8'h01;
    localparam logic [7:0] OP_ADD = 8'h05;

    typedef struct packed {
        logic [7:0]  op;
        logic [3:0]  rdst;
        logic [3:0]  rsrc1;
        logic [3:0]  rsrc2;
        logic        use_imm;
        logic [15:0] imm;
    } instr_t;

    // Bus select code: 0 means no driver, k+1 selects register k (max 16).
    function automatic logic [4:0] sel_code(input logic [3:0] idx);
        return {1'b0, idx} + 5'd1;
    endfunction

endpackage

// File: rtl/instr_sequencer_dec4to16.sv
// 4-to-16 one-hot decoder with a global enable; drives the register
// write-enable lines of the datapath.
module dec4to16 (
    input  logic        en_i,
    input  logic [3:0]  idx_i,
    output logic [15:0] onehot_o
);

    always_comb begin
        onehot_o        = '0;
        onehot_o[idx_i] = en_i;
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: accepts one instruction in IDLE, then
// steps RD_A -> RD_B -> EXEC -> DONE driving datapath selects from latched fields.
module instr_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic        reset,
    input  logic        clk,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [7:0]  instr_op,
    input  logic [3:0]  instr_rdst,
    input  logic [3:0]  instr_rsrc1,
    input  logic [3:0]  instr_rsrc2,
    input  logic        instr_use_imm,
    input  logic [15:0] instr_imm,
    output logic [15:0] immediate,
    output logic        imm_control,
    output logic        buff_en,
    output logic [15:0] enable,
    output logic [4:0]  control1,
    output logic [4:0]  control2,
    output logic [7:0]  opcode,
    output logic        busy,
    output logic        done,
    output logic [15:0] retire_count
);

    // Handshake: an instruction transfers on a rising edge where
    // instr_valid && instr_ready; instr_ready is high only in IDLE.

    logic [2:0]  state_q, state_d;
    instr_t      instr_q, instr_d;
    logic [15:0] retire_count_q, retire_count_d;
    logic        exec_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            instr_q        <= '0;
            retire_count_q <= '0;
        end else begin
            state_q        <= state_d;
            instr_q        <= instr_d;
            retire_count_q <= retire_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d.op      = instr_op;
                    instr_d.rdst    = instr_rdst;
                    instr_d.rsrc1   = instr_rsrc1;
                    instr_d.rsrc2   = instr_rsrc2;
                    instr_d.use_imm = instr_use_imm;
                    instr_d.imm     = instr_imm;
                    state_d         = (instr_op == OP_NOP) ? ST_DONE : ST_RD_A;
                end
            end
            ST_RD_A: state_d = ST_RD_B;
            ST_RD_B: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Count lands on entry to DONE so the retire pulse and the new count are seen together.
    always_comb begin
        retire_count_d = retire_count_q;
        if (state_d == ST_DONE) begin
            retire_count_d = retire_count_q + 16'd1;
        end
    end

    always_comb begin
        immediate   = '0;
        imm_control = 1'b0;
        buff_en     = 1'b0;
        control1    = '0;
        control2    = '0;
        opcode      = '0;
        exec_en     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_RD_A: begin
                busy     = 1'b1;
                control1 = sel_code(instr_q.rsrc1);
            end
            ST_RD_B: begin
                busy = 1'b1;
                if (instr_q.use_imm) begin
                    immediate   = instr_q.imm;
                    imm_control = 1'b1;
                end else begin
                    control2 = sel_code(instr_q.rsrc2);
                end
            end
            ST_EXEC: begin
                busy        = 1'b1;
                opcode      = instr_q.op;
                buff_en     = 1'b1;
                exec_en     = 1'b1;
                imm_control = instr_q.use_imm;
                immediate   = instr_q.use_imm ? instr_q.imm : 16'h0000;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign instr_ready  = (state_q == ST_IDLE);
    assign retire_count = retire_count_q;

    dec4to16 u_dec (
        .en_i     (exec_en),
        .idx_i    (instr_q.rdst),
        .onehot_o (enable)
    );

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table-driven instructions with a
// per-cycle expected queue, plus reset, latency, hold-off and wrap sequences.
module tb_instr_sequencer;

    localparam int W = 71;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic [7:0]  instr_op = '0;
    logic [3:0]  instr_rdst = '0;
    logic [3:0]  instr_rsrc1 = '0;
    logic [3:0]  instr_rsrc2 = '0;
    logic        instr_use_imm = 1'b0;
    logic [15:0] instr_imm = '0;

    logic        instr_ready;
    logic [15:0] immediate;
    logic        imm_control;
    logic        buff_en;
    logic [15:0] enable;
    logic [4:0]  control1;
    logic [4:0]  control2;
    logic [7:0]  opcode;
    logic        busy;
    logic        done;
    logic [15:0] retire_count;

    typedef struct packed {
        logic [7:0]  op;
        logic [3:0]  rdst;
        logic [3:0]  rsrc1;
        logic [3:0]  rsrc2;
        logic        use_imm;
        logic [15:0] imm;
    } tb_instr_t;

    typedef struct {
        tb_instr_t   f;
        logic [4:0]  c1;
        logic [4:0]  c2;
        logic [15:0] imm;
        logic        ic;
        logic [15:0] en;
    } rec_t;

    rec_t        tbl [6];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] obs;
    logic [15:0] rc_exp = '0;
    int          checks = 0;
    int          failures = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    instr_sequencer dut (
        .reset         (reset),
        .clk           (clk),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_op      (instr_op),
        .instr_rdst    (instr_rdst),
        .instr_rsrc1   (instr_rsrc1),
        .instr_rsrc2   (instr_rsrc2),
        .instr_use_imm (instr_use_imm),
        .instr_imm     (instr_imm),
        .immediate     (immediate),
        .imm_control   (imm_control),
        .buff_en       (buff_en),
        .enable        (enable),
        .control1      (control1),
        .control2      (control2),
        .opcode        (opcode),
        .busy          (busy),
        .done          (done),
        .retire_count  (retire_count)
    );

    assign obs = {instr_ready, busy, done, immediate, imm_control, buff_en,
                  enable, control1, control2, opcode, retire_count};

    // ---------------- model helpers ----------------
    function automatic logic [W-1:0] pack(input logic rdy, input logic bsy, input logic dn,
                                          input logic [15:0] imm, input logic ic, input logic bf,
                                          input logic [15:0] en, input logic [4:0] c1,
                                          input logic [4:0] c2, input logic [7:0] op,
                                          input logic [15:0] rc);
        return {rdy, bsy, dn, imm, ic, bf, en, c1, c2, op, rc};
    endfunction

    function automatic logic [W-1:0] idle_snap(input logic [15:0] rc);
        return pack(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 5'd0, 5'd0, 8'h0, rc);
    endfunction

    function automatic rec_t mk(input logic [7:0] op, input logic [3:0] rdst,
                                input logic [3:0] rs1, input logic [3:0] rs2,
                                input logic ui, input logic [15:0] imm,
                                input logic [4:0] c1, input logic [4:0] c2,
                                input logic [15:0] eimm, input logic ic,
                                input logic [15:0] en);
        rec_t r;
        r.f.op      = op;
        r.f.rdst    = rdst;
        r.f.rsrc1   = rs1;
        r.f.rsrc2   = rs2;
        r.f.use_imm = ui;
        r.f.imm     = imm;
        r.c1        = c1;
        r.c2        = c2;
        r.imm       = eimm;
        r.ic        = ic;
        r.en        = en;
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input tb_instr_t f, input logic v);
        instr_op      = f.op;
        instr_rdst    = f.rdst;
        instr_rsrc1   = f.rsrc1;
        instr_rsrc2   = f.rsrc2;
        instr_use_imm = f.use_imm;
        instr_imm     = f.imm;
        instr_valid   = v;
    endtask

    task automatic drive_random_valid();
        tb_instr_t g;
        g.op      = 8'($urandom_range(255));
        g.rdst    = 4'($urandom_range(15));
        g.rsrc1   = 4'($urandom_range(15));
        g.rsrc2   = 4'($urandom_range(15));
        g.use_imm = 1'($urandom_range(1));
        g.imm     = 16'($urandom_range(65535));
        drive(g, 1'b1);
    endtask

    // Offer one instruction in IDLE, queue the expected per-cycle outputs,
    // then pop and compare one entry per cycle until the queue drains.
    task automatic run_instr(input rec_t r, input bit keep_valid, input bit scramble,
                             input string tag);
        logic [W-1:0] exp;
        logic [15:0]  rc_next;
        @(negedge clk);
        drive(r.f, 1'b1);
        #1 check({tag, "_idle"}, obs, idle_snap(rc_exp));
        rc_next = rc_exp + 16'd1;
        if (r.f.op != 8'h00) begin
            exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, r.c1, 5'd0, 8'h0, rc_next - 16'd1));
            exp_q.push_back(pack(1'b0, 1'b1, 1'b0, r.imm, r.ic, 1'b0, 16'h0, 5'd0, r.c2, 8'h0, rc_next - 16'd1));
            exp_q.push_back(pack(1'b0, 1'b1, 1'b0, r.imm, r.ic, 1'b1, r.en, 5'd0, 5'd0, r.f.op, rc_next - 16'd1));
        end
        exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 16'h0, 5'd0, 5'd0, 8'h0, rc_next));
        rc_exp = rc_next;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            if (scramble) drive_random_valid();
            else if (!keep_valid) instr_valid = 1'b0;
            #1 exp = exp_q.pop_front();
            check(tag, obs, exp);
        end
    endtask

    // Falling edges from the accept edge until done is seen.
    task automatic measure(input tb_instr_t f, input int want, input string tag);
        int n;
        @(negedge clk);
        drive(f, 1'b1);
        @(negedge clk);
        instr_valid = 1'b0;
        #1 n = 1;
        while (!done && n < 8) begin
            @(negedge clk);
            #1 n++;
        end
        rc_exp = rc_exp + 16'd1;
        checks++;
        if (n != want) begin
            failures++;
            $display("FAIL %s latency actual=%0d required=%0d", tag, n, want);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        tbl[0] = mk(8'h05, 4'd0,  4'd0,  4'd0,  1'b1, 16'h0002, 5'd1,  5'd0,  16'h0002, 1'b1, 16'h0001);
        tbl[1] = mk(8'h01, 4'd15, 4'd3,  4'd7,  1'b0, 16'h0000, 5'd4,  5'd8,  16'h0000, 1'b0, 16'h8000);
        tbl[2] = mk(8'h05, 4'd7,  4'd15, 4'd15, 1'b0, 16'hFFFF, 5'd16, 5'd16, 16'h0000, 1'b0, 16'h0080);
        tbl[3] = mk(8'hFF, 4'd8,  4'd9,  4'd0,  1'b1, 16'hA5A5, 5'd10, 5'd0,  16'hA5A5, 1'b1, 16'h0100);
        tbl[4] = mk(8'h00, 4'd5,  4'd2,  4'd3,  1'b1, 16'h1234, 5'd0,  5'd0,  16'h0000, 1'b0, 16'h0000);
        tbl[5] = mk(8'h01, 4'd3,  4'd0,  4'd14, 1'b0, 16'h0000, 5'd1,  5'd15, 16'h0000, 1'b0, 16'h0008);

        // Held in reset with no clock dependence, then idle for 10 cycles.
        repeat (3) @(negedge clk);
        #1 check("in_reset", obs, idle_snap(16'h0000));
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 check("post_reset_idle", obs, idle_snap(16'h0000));
        end

        // Reset during EXEC discards the instruction.
        @(negedge clk);
        drive(tbl[0].f, 1'b1);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 check("exec_before_reset", obs,
                 pack(1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b1, 16'h0001, 5'd0, 5'd0, 8'h05, 16'h0000));
        reset = 1'b0;
        #1 check("reset_async", obs, idle_snap(16'h0000));
        repeat (3) begin
            @(negedge clk);
            #1 check("reset_hold", obs, idle_snap(16'h0000));
        end
        reset = 1'b1;
        @(negedge clk);
        #1 check("reset_release", obs, idle_snap(16'h0000));

        // Table vectors.
        for (int i = 0; i < 6; i++) begin
            run_instr(tbl[i], 1'b0, 1'b0, $sformatf("vec%0d", i));
        end

        measure(tbl[1].f, 4, "lat_and");
        measure(tbl[4].f, 1, "lat_nop");

        // NOP stream with valid held high: done every second cycle.
        for (int i = 0; i < 6; i++) begin
            run_instr(tbl[4], 1'b1, 1'b0, "nop_stream");
        end

        // Inputs change with valid high while busy; next instruction only after DONE.
        run_instr(tbl[1], 1'b0, 1'b1, "hold_busy");
        run_instr(tbl[0], 1'b0, 1'b0, "after_hold");
        run_instr(tbl[3], 1'b0, 1'b1, "hold_busy_imm");
        run_instr(tbl[2], 1'b0, 1'b0, "after_hold2");

        // Retire count up to 16'hFFFF with back-to-back NOPs, then wrap.
        @(negedge clk);
        drive(tbl[4].f, 1'b1);
        n = 32'h0000_FFFF - int'(rc_exp);
        repeat (2 * n) @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        #1 check("preload_ffff", obs, idle_snap(16'hFFFF));
        rc_exp = 16'hFFFF;
        run_instr(tbl[4], 1'b0, 1'b0, "wrap");
        @(negedge clk);
        #1 check("wrap_idle", obs, idle_snap(16'h0000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
